// File: rtl/vad_preroll_buffer.sv
// rtl/vad_preroll_buffer.sv - frame-energy voice activity detector with pre-roll sample buffer
//
// Purpose:
//   Every accepted PCM sample is written into a circular buffer. While the
//   detector reports SILENCE the buffer holds only the most recent PREROLL
//   samples and nothing is presented downstream. Once a frame's energy (sum of
//   |sample| over FRAME_LEN samples) exceeds THRESH, the buffer is streamed out
//   starting with the retained pre-roll, so the onset of speech is not clipped.
//   After speech ends the FSM tolerates HANG_FRAMES quiet frames, then drains
//   the buffer and returns to SILENCE.
//
// Ports:
//   clk, rst_n          single rising-edge clock, synchronous active-low reset
//   data_valid          qualifies i2s_data_in for one cycle
//   i2s_data_in         signed PCM sample
//   out_ready           downstream accepts out_data
//   out_data, out_valid oldest buffered sample and its valid flag
//   vad_raw, vad_valid  last frame decision and its one-cycle update strobe
//   speech_valid        state is SPEECH or HANG
//   vad_out             state is not SILENCE
//   buffer_state        SILENCE=0, SPEECH=1, HANG=2, DRAIN=3
//   overflow            sticky: a sample was dropped because the buffer was full

module vad_preroll_buffer #(
    parameter int          DATA_W      = 16,
    parameter int          FRAME_LEN   = 64,
    parameter int unsigned THRESH      = 32000,
    parameter int          HANG_FRAMES = 4,
    parameter int          DEPTH       = 256,
    parameter int          PREROLL     = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] i2s_data_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              vad_raw,
    output logic              vad_valid,
    output logic              speech_valid,
    output logic              vad_out,
    output logic [1:0]        buffer_state,
    output logic              overflow
);

    localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int ACC_W = DATA_W + $clog2(FRAME_LEN);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int HC_W  = (HANG_FRAMES > 1) ? $clog2(HANG_FRAMES) : 1;

    localparam logic [1:0] ST_SILENCE = 2'd0;
    localparam logic [1:0] ST_SPEECH  = 2'd1;
    localparam logic [1:0] ST_HANG    = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    // ------------------------------------------------------------------
    // Frame energy accumulation
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              vad_raw_q, vad_raw_d;
    logic              vad_valid_q, vad_valid_d;
    logic [DATA_W-1:0] abs_val;
    logic [ACC_W-1:0]  acc_sum;
    logic              frame_last;

    always_comb begin
        // Two's-complement negate of the most negative value yields
        // 2^(DATA_W-1) when read as unsigned, which is the wanted magnitude.
        abs_val    = i2s_data_in[DATA_W-1] ? ((~i2s_data_in) + DATA_W'(1)) : i2s_data_in;
        acc_sum    = acc_q + ACC_W'(abs_val);
        frame_last = (fcnt_q == FC_W'(FRAME_LEN - 1));

        acc_d       = acc_q;
        fcnt_d      = fcnt_q;
        vad_raw_d   = vad_raw_q;
        vad_valid_d = 1'b0;

        if (data_valid) begin
            if (frame_last) begin
                // Decision and clear happen on the same edge, so a sample in
                // the following (vad_valid) cycle lands in a fresh frame.
                acc_d       = '0;
                fcnt_d      = '0;
                vad_raw_d   = (64'(acc_sum) > 64'(THRESH));
                vad_valid_d = 1'b1;
            end else begin
                acc_d  = acc_sum;
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer control signals (needed by the FSM for the drain-empty test)
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [HC_W-1:0]   hang_q, hang_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic silence;
    logic ov_int;
    logic rd_en;
    logic wr_en;
    logic drop;
    logic at_preroll;
    logic full;

    // ------------------------------------------------------------------
    // Speech state machine; transitions only on a frame decision, except
    // DRAIN which also exits as soon as the buffer runs dry.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hang_d  = hang_q;
        case (state_q)
            ST_SILENCE: begin
                if (vad_valid_q && vad_raw_q) begin
                    state_d = ST_SPEECH;
                end
            end
            ST_SPEECH: begin
                if (vad_valid_q && !vad_raw_q) begin
                    state_d = ST_HANG;
                    hang_d  = HC_W'(HANG_FRAMES - 1);
                end
            end
            ST_HANG: begin
                if (vad_valid_q) begin
                    if (vad_raw_q) begin
                        state_d = ST_SPEECH;
                    end else if (hang_q == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        hang_d = hang_q - HC_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Renewed speech wins; remaining contents stay queued.
                if (vad_valid_q && vad_raw_q) begin
                    state_d = ST_SPEECH;
                end else if (cnt_q == '0) begin
                    state_d = ST_SILENCE;
                end
            end
            default: begin
                state_d = ST_SILENCE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Circular buffer
    // ------------------------------------------------------------------
    always_comb begin
        silence    = (state_q == ST_SILENCE);
        ov_int     = !silence && (cnt_q != '0);
        rd_en      = ov_int && out_ready;
        at_preroll = (cnt_q == CNT_W'(PREROLL));
        full       = (cnt_q == CNT_W'(DEPTH));

        // In SILENCE the count is capped at PREROLL <= DEPTH, so a write is
        // always possible there; a full buffer only refuses when not reading.
        wr_en = data_valid && (silence || !full || rd_en);
        drop  = data_valid && !silence && full && !rd_en;

        wptr_d     = wr_en ? (wptr_q + PTR_W'(1)) : wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | drop;

        if (silence) begin
            if (data_valid) begin
                if (at_preroll) begin
                    // Sliding pre-roll window: overwrite the oldest sample.
                    rptr_d = rptr_q + PTR_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            if (rd_en) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            fcnt_q      <= '0;
            vad_raw_q   <= 1'b0;
            vad_valid_q <= 1'b0;
            state_q     <= ST_SILENCE;
            hang_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fcnt_q      <= fcnt_d;
            vad_raw_q   <= vad_raw_d;
            vad_valid_q <= vad_valid_d;
            state_q     <= state_d;
            hang_q      <= hang_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= i2s_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid    = ov_int;
        // Gated so stale array contents never appear when nothing is valid.
        out_data     = ov_int ? mem_q[rptr_q] : '0;
        vad_raw      = vad_raw_q;
        vad_valid    = vad_valid_q;
        speech_valid = (state_q == ST_SPEECH) || (state_q == ST_HANG);
        vad_out      = (state_q != ST_SILENCE);
        buffer_state = state_q;
        overflow     = overflow_q;
    end

endmodule
